store_merge_ctrl: RTL

Store-side counterpart of the load-path extend logic. It narrows a 32-bit register value to a byte, halfword or word and writes it to memory.
- Sub-word stores (sb/sh) use a read-modify-write: read the aligned word, merge the byte lanes, write the word back.
- Word stores (sw) write directly.
- Sits between the multi-cycle control unit and the unified memory. The control unit holds its FSM until done or misaligned.

---
 rtl/mips_mem_pkg.sv | 38 +++
 rtl/store_lane_merge.sv | 37 +++
 rtl/store_merge_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory-side store/load helpers:
// access-size encodings, store controller state encoding and alignment rules.
package mips_mem_pkg;

    // Access size as presented by the control unit.
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;  // reserved, behaves as a word

    // Store controller states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAULT   = 3'd5
    } store_state_e;

    // True when the access needs a read-modify-write (byte or halfword).
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_HALF) || (size == SZ_BYTE);
    endfunction

    // True when the byte offset is illegal for the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian byte-lane merge: overlays the low byte/halfword of wdata onto
// an existing memory word at the given offset. Word accesses pass wdata through.
module store_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    // Select the target lanes from wdata, keep the rest from the old word.
    always_comb begin
        // NOTE: default assignment first so every path drives merged -- no latch.
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0]  = wdata[15:0];
                end
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/store_merge_ctrl.sv
// Store controller between the multi-cycle control unit and unified memory.
// Word stores write directly; byte/halfword stores read the aligned word,
// merge the target lanes and write it back. Misaligned stores are rejected.
module store_merge_ctrl
    import mips_mem_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,   // read latency in cycles, 1..4
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              misaligned
);

    // Two bits cover a wait of up to four cycles (counts MEM_RD_LAT-1 down to 0).
    localparam int CNT_W = 2;

    store_state_e      state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       merged;

    store_lane_merge u_merge (
        .old_word (rdata_q),
        .wdata    (wdata_q),
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .merged   (merged)
    );

    // State register; reset aborts any store in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking for all clocked state so every register sees pre-edge values.
            state <= state_nxt;
        end
    end

    // Request latch, read-wait counter and read-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: datapath registers are reset too, so nothing stale leaks out after an abort.
            addr_q   <= '0;
            size_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                addr_q  <= addr;
                size_q  <= size;
                wdata_q <= wdata;
            end
            if (state == ST_RD_REQ) begin
                wait_cnt <= CNT_W'(MEM_RD_LAT - 1);
            end
            if (state == ST_RD_WAIT) begin
                if (wait_cnt == '0) begin
                    rdata_q <= mem_rdata;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
        end
    end

    // Next-state and output decode; outputs depend on state only.
    always_comb begin
        state_nxt  = state;
        mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        mem_wdata  = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        misaligned = 1'b0;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                mem_addr = '0;
                if (start) begin
                    if (is_misaligned(size, addr[1:0])) begin
                        state_nxt = ST_FAULT;
                    end else if (is_subword(size)) begin
                        state_nxt = ST_RD_REQ;
                    end else begin
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_RD_REQ: begin
                mem_re    = 1'b1;
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = merged;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                misaligned = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
